// File: rtl/time_counter_bcd.sv
// BCD hh:mm:ss time-of-day counter with an internal 1 Hz prescaler, set/load controls and 12/24 h display.
// Define TIME_ALARM_EN to add the hh:mm alarm ports and registers.
module time_counter_bcd #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        set_mode,
    input  logic        inc_min,
    input  logic        inc_hour,
    input  logic        clr_sec,
    input  logic        load,
    input  logic [23:0] load_data,
    input  logic        fmt12,
    output logic [23:0] time_data,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_tick,
    output logic        load_err
`ifdef TIME_ALARM_EN
    ,
    input  logic        alarm_set,
    input  logic [15:0] alarm_data,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic        alarm
`endif
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
        else                     return 8'h00;
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)          return 8'h00;
        else if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
        else                     return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Full ripple carry seconds -> minutes -> hours in one step.
    function automatic logic [23:0] time_inc(input logic [23:0] t);
        if (t[7:0] != 8'h59)       return {t[23:8], bcd60_inc(t[7:0])};
        else if (t[15:8] != 8'h59) return {t[23:16], bcd60_inc(t[15:8]), 8'h00};
        else                       return {hour_inc(t[23:16]), 16'h0000};
    endfunction

    function automatic logic pair60_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_valid(input logic [7:0] h);
        return (h[3:0] <= 4'd9) && (h <= 8'h23);
    endfunction

    function automatic logic time_valid(input logic [23:0] t);
        return hour_valid(t[23:16]) && pair60_valid(t[15:8]) && pair60_valid(t[7:0]);
    endfunction

    // BCD subtract of 12 borrows from the tens digit when the units digit is below 2.
    function automatic logic [7:0] hour12(input logic [7:0] h);
        if (h == 8'h00)          return 8'h12;
        else if (h <= 8'h12)     return h;
        else if (h[3:0] >= 4'd2) return {h[7:4] - 4'd1, h[3:0] - 4'd2};
        else                     return {h[7:4] - 4'd2, h[3:0] + 4'd8};
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [23:0]      time_q, time_d;
    logic             sec_tick_q, sec_tick_d;
    logic             day_tick_q, day_tick_d;
    logic             load_err_q, load_err_d;
    logic             tick;

`ifdef TIME_ALARM_EN
    logic [15:0]      alarm_time_q, alarm_time_d;
    logic             alarm_q, alarm_d;
`endif

    always_comb begin
        div_d      = div_q;
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        load_err_d = 1'b0;
        tick       = run && !set_mode && (div_q == DIV_MAX);

        if (set_mode)  div_d = '0;
        else if (run)  div_d = tick ? '0 : div_q + 1'b1;

        // Load outranks set operations, which outrank the tick.
        if (load) begin
            if (time_valid(load_data)) begin
                time_d = load_data;
                div_d  = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (set_mode) begin
            time_d = {inc_hour ? hour_inc(time_q[23:16]) : time_q[23:16],
                      inc_min  ? bcd60_inc(time_q[15:8]) : time_q[15:8],
                      clr_sec  ? 8'h00 : time_q[7:0]};
        end else if (tick) begin
            time_d     = time_inc(time_q);
            sec_tick_d = 1'b1;
            day_tick_d = (time_q == 24'h235959);
        end

`ifdef TIME_ALARM_EN
        alarm_time_d = alarm_time_q;
        alarm_d      = alarm_q;
        if (alarm_set) begin
            if (hour_valid(alarm_data[15:8]) && pair60_valid(alarm_data[7:0]))
                alarm_time_d = alarm_data;
            else
                load_err_d = 1'b1;
        end
        // Only a counted second can raise the alarm; clears win.
        if (!alarm_en || alarm_ack)
            alarm_d = 1'b0;
        else if (sec_tick_d && (time_d == {alarm_time_q, 8'h00}))
            alarm_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q      <= '0;
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
`ifdef TIME_ALARM_EN
            alarm_time_q <= '0;
            alarm_q      <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
`ifdef TIME_ALARM_EN
            alarm_time_q <= alarm_time_d;
            alarm_q      <= alarm_d;
`endif
        end
    end

    assign time_data = fmt12 ? {hour12(time_q[23:16]), time_q[15:0]} : time_q;
    assign pm        = (time_q[23:16] >= 8'h12);
    assign sec_tick  = sec_tick_q;
    assign day_tick  = day_tick_q;
    assign load_err  = load_err_q;
`ifdef TIME_ALARM_EN
    assign alarm     = alarm_q;
`endif

endmodule

// File: tb/tb_time_counter_bcd.sv
// Scoreboard bench for time_counter_bcd with TICK_DIV=4: expectations are queued by the stimulus
// and popped by a monitor on every tick, day wrap, load error or explicit check strobe.
module tb_time_counter_bcd;

    logic        clk = 1'b0;
    logic        rst, run, set_mode, inc_min, inc_hour, clr_sec, load, fmt12;
    logic [23:0] load_data;
    logic [23:0] time_data;
    logic        pm, sec_tick, day_tick, load_err;
`ifdef TIME_ALARM_EN
    logic        alarm_set, alarm_en, alarm_ack, alarm;
    logic [15:0] alarm_data;
`endif

    time_counter_bcd #(.TICK_DIV(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
        .load(load), .load_data(load_data), .fmt12(fmt12),
        .time_data(time_data), .pm(pm), .sec_tick(sec_tick),
        .day_tick(day_tick), .load_err(load_err)
`ifdef TIME_ALARM_EN
        ,
        .alarm_set(alarm_set), .alarm_data(alarm_data), .alarm_en(alarm_en),
        .alarm_ack(alarm_ack), .alarm(alarm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] td;
        logic        pm, st, dt, le, al;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    logic chk_req = 1'b0;
    logic exp_al = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sec_tick || day_tick || load_err || chk_req) begin
            exp_t e;
            logic bad;
            tests++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: td=%h st=%b dt=%b le=%b at cyc %0d, required no event",
                         time_data, sec_tick, day_tick, load_err, cyc);
            end else begin
                e = q.pop_front();
                bad = (time_data !== e.td) || (pm !== e.pm) || (sec_tick !== e.st) ||
                      (day_tick !== e.dt) || (load_err !== e.le) ||
                      ((e.cyc >= 0) && (cyc != e.cyc));
`ifdef TIME_ALARM_EN
                if (alarm !== e.al) bad = 1'b1;
`endif
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got td=%h pm=%b st=%b dt=%b le=%b cyc=%0d, required td=%h pm=%b st=%b dt=%b le=%b al=%b cyc=%0d",
                             e.name, time_data, pm, sec_tick, day_tick, load_err, cyc,
                             e.td, e.pm, e.st, e.dt, e.le, e.al, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string nm, input logic [23:0] td, input logic p,
                        input logic st, input logic dt, input logic le, input int cy);
        exp_t e;
        e.name = nm; e.td = td; e.pm = p; e.st = st; e.dt = dt; e.le = le;
        e.al = exp_al; e.cyc = cy;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [23:0] td, input logic p);
        push(nm, td, p, 1'b0, 1'b0, 1'b0, -1);
        chk_req = 1'b1;
        step(1);
        chk_req = 1'b0;
    endtask

    task automatic load_ok(input logic [23:0] d);
        load_data = d;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic load_bad(input string nm, input logic [23:0] d, input logic [23:0] cur, input logic p);
        load_data = d;
        load = 1'b1;
        push(nm, cur, p, 1'b0, 1'b0, 1'b1, -1);
        step(1);
        load = 1'b0;
        step(1);
    endtask

    initial begin
        int c0;
        logic [23:0] v;
        rst = 1'b0; run = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        clr_sec = 1'b0; load = 1'b0; fmt12 = 1'b0; load_data = '0;
`ifdef TIME_ALARM_EN
        alarm_set = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0; alarm_data = '0;
`endif
        step(2);
        chk("rst_24h", 24'h000000, 1'b0);
        fmt12 = 1'b1;
        chk("rst_12h", 24'h120000, 1'b0);
        fmt12 = 1'b0;

        // Count ten seconds from reset, one tick every fourth cycle.
        rst = 1'b1; run = 1'b1; c0 = cyc;
        for (int i = 1; i <= 10; i++) begin
            v = (i < 10) ? 24'(i) : 24'h000010;
            push("count_tick", v, 1'b0, 1'b1, 1'b0, 1'b0, c0 + 4 * i);
        end
        step(40);
        run = 1'b0;
        step(1);
        chk("count_hold", 24'h000010, 1'b0);

        // Midnight wrap.
        load_ok(24'h235959);
        chk("day_pre", 24'h235959, 1'b1);
        run = 1'b1; c0 = cyc;
        push("day_wrap", 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, c0 + 4);
        step(4);
        run = 1'b0;
        step(1);
        chk("day_post", 24'h000000, 1'b0);

        // Set mode entered mid-count; prescaler must restart on exit.
        load_ok(24'h125930);
        run = 1'b1;
        step(2);
        set_mode = 1'b1; inc_min = 1'b1;
        step(2);
        inc_min = 1'b0; inc_hour = 1'b1;
        step(12);
        inc_hour = 1'b0;
        chk("set_adj", 24'h000130, 1'b0);
        clr_sec = 1'b1;
        step(1);
        clr_sec = 1'b0;
        chk("set_clr", 24'h000100, 1'b0);
        inc_min = 1'b1; inc_hour = 1'b1;
        step(1);
        inc_min = 1'b0; inc_hour = 1'b0;
        chk("set_multi", 24'h010200, 1'b0);
        set_mode = 1'b0; c0 = cyc;
        push("set_exit", 24'h010201, 1'b0, 1'b1, 1'b0, 1'b0, c0 + 4);
        step(4);
        run = 1'b0;
        step(1);

        // Rejected loads.
        load_bad("bad_hour", 24'h246000, 24'h010201, 1'b0);
        load_bad("bad_sec", 24'h095960, 24'h010201, 1'b0);
        load_bad("bad_digit", 24'h0A0000, 24'h010201, 1'b0);
        chk("bad_keep", 24'h010201, 1'b0);

        // A load on the tick edge suppresses the tick.
        run = 1'b1;
        load_ok(24'h101010);
        step(3);
        load_data = 24'h202020; load = 1'b1;
        step(1);
        load = 1'b0; run = 1'b0;
        chk("load_over_tick", 24'h202020, 1'b1);

        // 12 h display.
        load_ok(24'h000500);
        fmt12 = 1'b1;  chk("h12_midnight", 24'h120500, 1'b0);
        fmt12 = 1'b0;  chk("h24_midnight", 24'h000500, 1'b0);
        load_ok(24'h130000);
        fmt12 = 1'b1;  chk("h12_13", 24'h010000, 1'b1);
        fmt12 = 1'b0;  chk("h24_13", 24'h130000, 1'b1);
        load_ok(24'h120000);
        fmt12 = 1'b1;  chk("h12_noon", 24'h120000, 1'b1);
        load_ok(24'h235959);
        chk("h12_23", 24'h115959, 1'b1);
        load_ok(24'h110000);
        chk("h12_11", 24'h110000, 1'b0);
        fmt12 = 1'b0;

        // Reset wins over a same-cycle load.
        run = 1'b1; load_data = 24'h123456; load = 1'b1; rst = 1'b0;
        step(1);
        load = 1'b0; rst = 1'b1; run = 1'b0;
        chk("rst_prio", 24'h000000, 1'b0);

`ifdef TIME_ALARM_EN
        alarm_en = 1'b1; alarm_data = 16'h0701; alarm_set = 1'b1;
        step(1);
        alarm_set = 1'b0;
        load_ok(24'h070059);
        chk("alm_pre", 24'h070059, 1'b0);
        run = 1'b1; c0 = cyc; exp_al = 1'b1;
        push("alm_tick", 24'h070100, 1'b0, 1'b1, 1'b0, 1'b0, c0 + 4);
        step(4);
        run = 1'b0;
        step(1);
        chk("alm_hold", 24'h070100, 1'b0);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0; exp_al = 1'b0;
        chk("alm_ack", 24'h070100, 1'b0);
        load_ok(24'h070100);
        chk("alm_by_load", 24'h070100, 1'b0);
        alarm_data = 16'h2400; alarm_set = 1'b1;
        push("alm_bad", 24'h070100, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        step(1);
        alarm_set = 1'b0;
        step(1);
`endif

        step(2);
        if (q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/time_counter_bcd.md
# time_counter_bcd

- Parametrised synchronous BCD time-of-day counter (hh:mm:ss) for the clock display path.
- Runs on the single system clock and divides it internally into a once-per-second count enable; no derived or rippled clocks.
- Adds field set controls, parallel load with validation, runtime 12/24-hour display formatting, and an optional alarm.
- Output feeds the seven-segment display driver.

## Interface
Parameters:
- `TICK_DIV`, 50000000: clk cycles per counted second; legal range 1..2^32-1; 1 counts every cycle.
- `DIV_W`, 32: prescaler width; must satisfy 2^DIV_W > TICK_DIV-1.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous active-low reset (one clock; reset is synchronous and active-low).
- `run` input 1: 1 = timekeeping enabled.
- `set_mode` input 1: 1 = adjust mode; timekeeping frozen.
- `inc_min` input 1: one-cycle pulse, minute +1 (set_mode only).
- `inc_hour` input 1: one-cycle pulse, hour +1 (set_mode only).
- `clr_sec` input 1: one-cycle pulse, seconds := 00 (set_mode only).
- `load` input 1: one-cycle pulse, load `load_data`.
- `load_data` input 24: BCD {H1,H0,M1,M0,S1,S0}, 24 h format.
- `fmt12` input 1: 1 = `time_data` hours shown in 12 h format.
- `time_data` output 24: BCD {H1,H0,M1,M0,S1,S0}.
- `pm` output 1: 1 when internal hour >= 12 (both formats).
- `sec_tick` output 1: one-cycle pulse on each counted second.
- `day_tick` output 1: one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- State: six 4-bit BCD digit registers holding 24 h time. Prescaler `div_cnt` counts 0..TICK_DIV-1.
- Counting (`run`=1, `set_mode`=0):
  - `div_cnt` increments each cycle.
  - At TICK_DIV-1 it wraps to 0 and a tick occurs.
  - A tick increments seconds with full ripple carry S0->S1->M0->M1->H0/H1, all in the same edge.
  - Limits: S0,M0 0..9; S1,M1 0..5; hours 00..23. At 23 the hour wraps to 00 (H0 does not reach 4 when H1=2).
- `run`=0: `div_cnt` and time hold; no ticks.
- `set_mode`=1:
  - `div_cnt` is forced to 0; no ticks.
  - `inc_min`: minute mod 60, no carry to the hour.
  - `inc_hour`: hour mod 24.
  - `clr_sec`: seconds := 00.
  - Multiple set pulses in one cycle apply together.
  - Leaving set_mode: the first tick occurs TICK_DIV cycles later.
- `load`:
  - Accepted in any mode.
  - Valid when every digit <= 9, S1/M1 <= 5, and hour <= 23.
  - Valid load: time := load_data and `div_cnt` := 0.
  - Invalid load: time unchanged and `load_err` pulses.
- Priority per cycle: rst > load > set operations > tick. A same-cycle tick is discarded when load or a set operation is applied.
- 12 h conversion is combinational from the state registers:
  - hour 00 -> 12, `pm`=0
  - 01..11 -> unchanged, `pm`=0
  - 12 -> 12, `pm`=1
  - 13..23 -> hour-12, `pm`=1
- `fmt12` affects `time_data` only; it never changes internal state.

## Timing
- Reset (rst=0 at posedge): digits 0, `div_cnt` 0, and all pulse outputs 0. `time_data` then reads 000000, or 120000 when `fmt12`=1. `pm`=0.
- Reset mid-count wins over load, set and tick in the same cycle.
- The tick edge updates the digits, `sec_tick`, and `day_tick` together. They are visible after that edge (registered, zero added latency).
- `load`, `inc_*`, and `clr_sec` take effect on the edge that samples them. `load_err` is registered at that edge.
- `fmt12` reaches `time_data` combinationally in the same cycle.
- Ticks are spaced exactly TICK_DIV cycles apart while counting.

## Configuration
- `TIME_ALARM_EN` defined: adds the following ports.
  - `alarm_set` (in, 1): loads `alarm_data`.
  - `alarm_data` (in, 16): BCD hh:mm, 24 h format. Invalid values are ignored and pulse `load_err`.
  - `alarm_en` (in, 1): enables the alarm.
  - `alarm_ack` (in, 1): clears the alarm.
  - `alarm` (out, 1): registered alarm level.
- Alarm set: `alarm` goes to 1 on the tick edge that produces hh:mm:00 equal to the alarm time, while `alarm_en`=1.
- Alarm is never set by load or set operations.
- Alarm clear: cleared by `alarm_ack`, by `alarm_en`=0, or by reset. Clear wins over a same-cycle set.
- Alarm registers reset to 00:00.
- `TIME_ALARM_EN` undefined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset then count: TICK_DIV=4, run=1 for 40 cycles. Expect `time_data`=000010 and `sec_tick` every 4th cycle.
- Day wrap: load 235959, then one tick. Expect 000000, `day_tick` high for exactly 1 cycle, and `pm` 1 -> 0.
- Set mode: from 125930, set_mode=1 with inc_min x2 and inc_hour x12. Expect 000130 with no ticks during set_mode. Then clr_sec gives 000100.
- Invalid load: load_data=246000. Expect time unchanged and `load_err` for 1 cycle. load_data=095960 is also rejected.
- 12 h display: internal 000500 -> 120500 with pm=0; internal 130000 -> 010000 with pm=1. Toggling `fmt12` changes only the hour digits.
- Alarm (TIME_ALARM_EN): alarm 0701, time loaded 070059, one tick -> `alarm`=1. alarm_ack -> 0. Reaching 0701 via load keeps `alarm`=0.
